vga_ctrl_param: RTL and testbench

Parametrised VGA timing generator and pixel pipeline, the successor to the fixed 640x480 `vga_ctrl`. It produces horizontal and vertical pixel addresses for a framebuffer such as `vmem`. It delays sync and blank by a configurable memory read latency so they stay aligned with returned pixel data, and it supports integer pixel replication (scaling). A clock-enable and frame/line strobes are provided. It sits between the framebuffer and the NVBoard VGA pins (VGA_HSYNC, VGA_VSYNC, VGA_BLANK_N, VGA_R/G/B).

---
 rtl/vga_ctrl_param.sv | 121 ++++++++++++
 tb/tb_vga_ctrl_param.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_ctrl_param.sv
// Parametrised VGA timing generator: pixel/line counters, framebuffer addresses,
// and a sync/blank pipeline delayed to line up with the framebuffer read latency.
module vga_ctrl_param #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter logic SYNC_POL    = 1'b0,
   parameter int   RD_LAT      = 1,
   parameter int   SCALE_SHIFT = 0,
   parameter int   AW          = 10
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          en,
   input  logic [23:0]   vga_data,
   output logic [AW-1:0] h_addr,
   output logic [AW-1:0] v_addr,
   output logic          hsync,
   output logic          vsync,
   output logic          valid,
   output logic [7:0]    vga_r,
   output logic [7:0]    vga_g,
   output logic [7:0]    vga_b,
   output logic          frame_start,
   output logic          line_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SBEG_C = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SEND_C = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SBEG_C = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SEND_C = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

   logic [HW-1:0] r_h_cnt;
   logic [VW-1:0] r_v_cnt;
   logic          w_h_last, w_v_last;

   assign w_h_last = (r_h_cnt == H_LAST_C);
   assign w_v_last = (r_v_cnt == V_LAST_C);

   // NOTE: reset is tested before en in the same always_ff, so reset wins over a frozen clock-enable.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (en) begin
         if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
         end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
         end
      end
   end

   logic          w_h_act, w_v_act, w_active;
   logic          w_hs, w_vs, w_fs, w_ls;
   logic [HW-1:0] w_h_shift;
   logic [VW-1:0] w_v_shift;

   assign w_h_act   = (r_h_cnt < H_ACT_C);
   assign w_v_act   = (r_v_cnt < V_ACT_C);
   assign w_active  = w_h_act && w_v_act;
   assign w_hs      = (r_h_cnt >= H_SBEG_C && r_h_cnt < H_SEND_C) ? SYNC_POL : ~SYNC_POL;
   assign w_vs      = (r_v_cnt >= V_SBEG_C && r_v_cnt < V_SEND_C) ? SYNC_POL : ~SYNC_POL;
   assign w_fs      = (r_h_cnt == '0) && (r_v_cnt == '0);
   assign w_ls      = (r_h_cnt == '0) && w_v_act;
   assign w_h_shift = r_h_cnt >> SCALE_SHIFT;
   assign w_v_shift = r_v_cnt >> SCALE_SHIFT;
   assign h_addr    = w_active ? AW'(w_h_shift) : '0;
   assign v_addr    = w_active ? AW'(w_v_shift) : '0;

   // Stage 0 captures the counter-derived flags; stage RD_LAT-1 is the output.
   logic [RD_LAT-1:0] r_hs_pipe, r_vs_pipe, r_vld_pipe, r_fs_pipe, r_ls_pipe;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hs_pipe  <= {RD_LAT{~SYNC_POL}};
         r_vs_pipe  <= {RD_LAT{~SYNC_POL}};
         r_vld_pipe <= '0;
         r_fs_pipe  <= '0;
         r_ls_pipe  <= '0;
      end else if (en) begin
         r_hs_pipe[0]  <= w_hs;
         r_vs_pipe[0]  <= w_vs;
         r_vld_pipe[0] <= w_active;
         r_fs_pipe[0]  <= w_fs;
         r_ls_pipe[0]  <= w_ls;
         for (int i = 1; i < RD_LAT; i++) begin
            r_hs_pipe[i]  <= r_hs_pipe[i-1];
            r_vs_pipe[i]  <= r_vs_pipe[i-1];
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_fs_pipe[i]  <= r_fs_pipe[i-1];
            r_ls_pipe[i]  <= r_ls_pipe[i-1];
         end
      end
   end

   assign hsync       = r_hs_pipe[RD_LAT-1];
   assign vsync       = r_vs_pipe[RD_LAT-1];
   assign valid       = r_vld_pipe[RD_LAT-1];
   assign frame_start = r_fs_pipe[RD_LAT-1];
   assign line_start  = r_ls_pipe[RD_LAT-1];

   // Colour is gated live so it tracks vga_data even while en holds the pipeline.
   assign {vga_r, vga_g, vga_b} = valid ? vga_data : 24'h0;

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Bench for vga_ctrl_param on a small raster: a linear pixel-index model predicts
// every output each clock, with literal spot checks on release, freeze and reset.
module tb_vga_ctrl_param;

   localparam int   HA = 16, HF = 2, HS = 3, HB = 4;
   localparam int   VA = 12, VF = 1, VS = 2, VB = 2;
   localparam int   HT = HA + HF + HS + HB;   // 25
   localparam int   VT = VA + VF + VS + VB;   // 17
   localparam int   FT = HT * VT;             // 425
   localparam bit   SP = 1'b0;
   localparam int   RL = 2;
   localparam int   SS = 1;
   localparam int   AW = 10;

   logic          clk = 1'b0;
   logic          resetn, en;
   logic [23:0]   vga_data;
   logic [AW-1:0] h_addr, v_addr;
   logic          hsync, vsync, valid, frame_start, line_start;
   logic [7:0]    vga_r, vga_g, vga_b;

   always #5 clk = ~clk;

   vga_ctrl_param #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(SP), .RD_LAT(RL), .SCALE_SHIFT(SS), .AW(AW)
   ) dut (
      .clk(clk), .resetn(resetn), .en(en), .vga_data(vga_data),
      .h_addr(h_addr), .v_addr(v_addr), .hsync(hsync), .vsync(vsync),
      .valid(valid), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start), .line_start(line_start)
   );

   int n_vec = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one linear pixel index per enabled clock.
   function automatic bit m_active(int p);
      return (p % HT) < HA && (p / HT) < VA;
   endfunction
   function automatic bit m_hs(int p);
      int h = p % HT;
      return (h >= HA + HF && h < HA + HF + HS) ? SP : !SP;
   endfunction
   function automatic bit m_vs(int p);
      int v = p / HT;
      return (v >= VA + VF && v < VA + VF + VS) ? SP : !SP;
   endfunction

   int m_pos = 0, m_since = 0;
   bit m_ok = 1'b0;
   bit r_e, e_e;
   int p, exp_h, exp_v;
   bit idle, exp_vld, exp_hs, exp_vs, exp_fs, exp_ls;
   int fs_cnt = 0, hs_run = 0, vs_run = 0, vld_run = 0;
   bit fs_have = 1'b0;

   always @(posedge clk) begin
      r_e = resetn;
      e_e = en;
      if (!r_e) begin
         m_pos = 0; m_since = 0; m_ok = 1'b1;
      end else if (e_e && m_ok) begin
         m_pos = (m_pos + 1) % FT;
         if (m_since < RL) m_since++;
      end
      #1;
      if (m_ok) begin
         idle    = (m_since < RL);
         p       = (m_pos - RL + FT) % FT;
         exp_vld = idle ? 1'b0 : m_active(p);
         exp_hs  = idle ? !SP : m_hs(p);
         exp_vs  = idle ? !SP : m_vs(p);
         exp_fs  = !idle && (p == 0);
         exp_ls  = !idle && (p % HT == 0) && (p / HT < VA);
         exp_h   = m_active(m_pos) ? ((m_pos % HT) >> SS) : 0;
         exp_v   = m_active(m_pos) ? ((m_pos / HT) >> SS) : 0;
         check("h_addr", 32'(h_addr), 32'(exp_h));
         check("v_addr", 32'(v_addr), 32'(exp_v));
         check("hsync", 32'(hsync), 32'(exp_hs));
         check("vsync", 32'(vsync), 32'(exp_vs));
         check("valid", 32'(valid), 32'(exp_vld));
         check("frame_start", 32'(frame_start), 32'(exp_fs));
         check("line_start", 32'(line_start), 32'(exp_ls));
         check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_vld ? vga_data : 24'h0));

         if (!r_e) begin
            fs_cnt = 0; fs_have = 1'b0; hs_run = 0; vs_run = 0; vld_run = 0;
         end else if (e_e) begin
            if (hsync == SP) hs_run++;
            else if (hs_run > 0) begin check("hsync_width", 32'(hs_run), 32'd3); hs_run = 0; end
            if (vsync == SP) vs_run++;
            else if (vs_run > 0) begin check("vsync_width", 32'(vs_run), 32'd50); vs_run = 0; end
            if (valid) vld_run++;
            else if (vld_run > 0) begin check("valid_width", 32'(vld_run), 32'd16); vld_run = 0; end
            fs_cnt++;
            if (frame_start) begin
               if (fs_have) check("frame_period", 32'(fs_cnt), 32'd425);
               fs_have = 1'b1;
               fs_cnt  = 0;
            end
         end
      end
   end

   task automatic step(input logic rv, input logic ev, input logic [23:0] dv);
      @(negedge clk);
      resetn   = rv;
      en       = ev;
      vga_data = dv;
      @(posedge clk);
      #2;
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 2000 && m_pos != target; i++) step(1'b1, 1'b1, 24'($urandom));
      check("run_to_reached", 32'(m_pos == target), 32'd1);
   endtask

   initial begin
      resetn = 1'b0; en = 1'b0; vga_data = 24'h0;
      repeat (3) step(1'b0, 1'($urandom % 2), 24'hABCDEF);
      // Release: with RD_LAT=2 first valid pixel appears two clocks later.
      check("rel0_valid", 32'(valid), 32'd0);
      check("rel0_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      check("rel0_hsync", 32'(hsync), 32'd1);
      step(1'b1, 1'b1, 24'hABCDEF);
      check("rel1_valid", 32'(valid), 32'd0);
      check("rel1_haddr", 32'(h_addr), 32'd0);
      step(1'b1, 1'b1, 24'hABCDEF);
      check("rel2_valid", 32'(valid), 32'd1);
      check("rel2_fs", 32'(frame_start), 32'd1);
      check("rel2_rgb", 32'({vga_r, vga_g, vga_b}), 32'hABCDEF);
      check("rel2_haddr", 32'(h_addr), 32'd1);

      repeat (900) step(1'b1, 1'b1, 24'($urandom));

      // Freeze at h=10, v=5 for 37 clocks.
      run_to(5 * HT + 10);
      for (int i = 0; i < 37; i++) begin
         step(1'b1, 1'b0, 24'($urandom));
         check("frz_haddr", 32'(h_addr), 32'd5);
         check("frz_valid", 32'(valid), 32'd1);
         check("frz_hsync", 32'(hsync), 32'd1);
      end
      step(1'b1, 1'b1, 24'($urandom));
      check("unfrz_haddr0", 32'(h_addr), 32'd5);
      step(1'b1, 1'b1, 24'($urandom));
      check("unfrz_haddr1", 32'(h_addr), 32'd6);

      // One-clock reset with counters at h=20, v=13 (output inside hsync and vsync).
      run_to(13 * HT + 20);
      check("pre_rst_hsync", 32'(hsync), 32'd0);
      check("pre_rst_vsync", 32'(vsync), 32'd0);
      step(1'b0, 1'b1, 24'($urandom));
      check("rst_haddr", 32'(h_addr), 32'd0);
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_valid", 32'(valid), 32'd0);
      step(1'b1, 1'b1, 24'($urandom));
      check("rst1_fs", 32'(frame_start), 32'd0);
      step(1'b1, 1'b1, 24'($urandom));
      check("rst2_fs", 32'(frame_start), 32'd1);
      check("rst2_valid", 32'(valid), 32'd1);

      for (int i = 0; i < 2500; i++)
         step(($urandom % 700) != 0, ($urandom % 4) != 0, 24'($urandom));

      repeat (900) step(1'b1, 1'b1, 24'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
